input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner_pkg.sv | 13 +
 rtl/debounce_filter.sv | 56 +++++
 rtl/input_conditioner.sv | 91 +++++++++
 tb/tb_input_conditioner.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared types and defaults for the button/switch input conditioner.
// Holds the button state encoding and the default debounce window.
package input_conditioner_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } btn_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int CNT_W_DEF = 20;

endpackage

// File: rtl/debounce_filter.sv
// One input channel: 2-flop synchronizer, run-length counter, stable level.
// acc_o strobes on the edge where a new level is accepted.
module debounce_filter
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic acc_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0] sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic level_q, level_d;
  logic acc;
  logic synced;

  assign synced = sync_q[1];

  // Any cycle of agreement drops all progress toward a new level.
  always_comb begin
    cnt_d = '0;
    level_d = level_q;
    acc = 1'b0;
    if (synced != level_q) begin
      if (cnt_q == LAST) begin
        acc = 1'b1;
        level_d = synced;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      cnt_q <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
  assign acc_o = acc;

endmodule

// File: rtl/input_conditioner.sv
// Debounces step button and w switch; emits one step pulse per press,
// a press counter, and the switch level latched at each press.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       sw_raw,
  output logic       step_pulse,
  output logic       w_out,
  output logic       w_sampled,
  output logic       btn_level,
  output logic [7:0] step_count
);

  logic btn_lvl, btn_acc;
  logic sw_lvl, sw_acc_unused;

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W(CNT_W)
  ) u_btn (
    .clk(clk),
    .rst_n(reset),
    .raw_i(btn_raw),
    .level_o(btn_lvl),
    .acc_o(btn_acc)
  );

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W(CNT_W)
  ) u_sw (
    .clk(clk),
    .rst_n(reset),
    .raw_i(sw_raw),
    .level_o(sw_lvl),
    .acc_o(sw_acc_unused)
  );

  btn_state_e state_q, state_d;
  logic pulse_q, pulse_d;
  logic ws_q, ws_d;
  logic [7:0] cnt_q, cnt_d;

  // w is captured on the accepting edge, so a same-edge switch change
  // still yields the pre-change level.
  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
    ws_d = ws_q;
    cnt_d = pulse_q ? cnt_q + 8'd1 : cnt_q;
    unique case (state_q)
      IDLE: begin
        if (btn_acc) begin
          state_d = HELD;
          pulse_d = 1'b1;
          ws_d = sw_lvl;
        end
      end
      HELD: begin
        if (btn_acc) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pulse_q <= 1'b0;
      ws_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      ws_q <= ws_d;
      cnt_q <= cnt_d;
    end
  end

  assign step_pulse = pulse_q;
  assign w_out = sw_lvl;
  assign w_sampled = ws_q;
  assign btn_level = btn_lvl;
  assign step_count = cnt_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a 4-cycle debounce window.
// Vector table for the main press/switch flow, hand sequences for corners.
module tb_input_conditioner;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_raw = 1'b0;
  logic sw_raw = 1'b0;
  logic step_pulse, w_out, w_sampled, btn_level;
  logic [7:0] step_count;

  input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .sw_raw(sw_raw),
    .step_pulse(step_pulse),
    .w_out(w_out),
    .w_sampled(w_sampled),
    .btn_level(btn_level),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;

  always @(negedge clk) if (step_pulse) pulses++;

  typedef struct {
    logic rst, b, s;
    logic ep, el, ew, ews;
    logic [7:0] ec;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, b, s, ep, el, ew, ews,
                     input logic [7:0] ec);
    vec_t v;
    v.rst = rst; v.b = b; v.s = s;
    v.ep = ep; v.el = el; v.ew = ew; v.ews = ews; v.ec = ec;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_pulse(input int maxn, output int n);
    n = -1;
    for (int i = 1; i <= maxn; i++) begin
      tick();
      if (step_pulse) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_step"}, int'(step_pulse), 0);
    check({tag, "_lvl"}, int'(btn_level), 0);
    check({tag, "_wout"}, int'(w_out), 0);
    check({tag, "_wsmp"}, int'(w_sampled), 0);
    check({tag, "_cnt"}, int'(step_count), 0);
  endtask

  initial begin
    int n;
    int p0;
    // rst b s | step lvl w ws cnt
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 1, 1, 1, 1, 0, 0);
    add(1, 1, 1, 0, 1, 1, 0, 1);
    for (int i = 0; i < 5; i++) add(1, 0, 1, 0, 1, 1, 0, 1);
    add(1, 0, 1, 0, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) add(1, 1, 1, 0, 0, 1, 0, 1);
    add(1, 1, 1, 1, 1, 1, 1, 1);
    add(1, 1, 1, 0, 1, 1, 1, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst;
      btn_raw = vecs[i].b;
      sw_raw = vecs[i].s;
      tick();
      check($sformatf("v%0d_step", i), int'(step_pulse), int'(vecs[i].ep));
      check($sformatf("v%0d_lvl", i), int'(btn_level), int'(vecs[i].el));
      check($sformatf("v%0d_wout", i), int'(w_out), int'(vecs[i].ew));
      check($sformatf("v%0d_wsmp", i), int'(w_sampled), int'(vecs[i].ews));
      check($sformatf("v%0d_cnt", i), int'(step_count), int'(vecs[i].ec));
    end

    btn_raw = 0;
    ticks(8);
    check("rel_lvl", int'(btn_level), 0);

    p0 = pulses;
    btn_raw = 1; tick();
    btn_raw = 0; tick();
    btn_raw = 1; tick();
    btn_raw = 0; tick();
    check("bounce_nopulse", pulses - p0, 0);
    btn_raw = 1;
    wait_pulse(20, n);
    check("bounce_lat", n, 6);
    ticks(100);
    check("hold_lvl", int'(btn_level), 1);
    btn_raw = 0;
    ticks(5);
    check("rel_lvl_early", int'(btn_level), 1);
    tick();
    check("rel_lvl_late", int'(btn_level), 0);
    ticks(4);
    check("hold_pulses", pulses - p0, 1);
    check("hold_cnt", int'(step_count), 3);

    sw_raw = 0;
    ticks(8);
    check("sw0_wout", int'(w_out), 0);
    btn_raw = 1;
    wait_pulse(20, n);
    check("sw0_lat", n, 6);
    tick();
    check("sw0_wsmp", int'(w_sampled), 0);
    check("sw0_cnt", int'(step_count), 4);
    btn_raw = 0;
    ticks(8);

    reset = 0;
    sw_raw = 1;
    tick();
    check_all_zero("rst1");
    reset = 1;
    for (int i = 0; i < 255; i++) begin
      btn_raw = 1; ticks(8);
      btn_raw = 0; ticks(8);
    end
    check("wrap_255", int'(step_count), 255);
    check("wrap_wsmp", int'(w_sampled), 1);
    btn_raw = 1; ticks(8);
    btn_raw = 0; ticks(8);
    check("wrap_0", int'(step_count), 0);

    p0 = pulses;
    btn_raw = 1;
    ticks(3);
    reset = 0;
    tick();
    check_all_zero("rst_mid");
    reset = 1;
    wait_pulse(20, n);
    check("rst_mid_lat", n, 6);
    check("rst_mid_wout", int'(w_out), 1);
    check("rst_mid_wsmp", int'(w_sampled), 0);
    tick();
    check("rst_mid_cnt", int'(step_count), 1);
    check("rst_mid_pulses", pulses - p0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
